// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : shared seven-segment pattern table, FSM states and decode helper
// Revision : 1.0
// ============================================================================
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } seg7_state_t;

  // Segment patterns (gfedcba), index = hex digit; shared with the encoder side.
  localparam logic [15:0][6:0] c_seg_table = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [4:0] seg7_to_hex(input logic [6:0] pattern);
    logic [4:0] result;
    result = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == c_seg_table[i]) result = {1'b1, i[3:0]};
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_lut.sv
`default_nettype none
// ============================================================================
// seg7_pattern_lut : combinational segment pattern -> {hit, hex nibble}
// Revision : 1.0
// ============================================================================
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_hit,
  output logic [3:0] o_nibble
);

  assign {o_hit, o_nibble} = seg7_to_hex(i_pattern);

endmodule
`default_nettype wire

// File: rtl/seg7_stream_decoder.sv
`default_nettype none
// ============================================================================
// seg7_stream_decoder : serial seven-segment frame receiver with hex decode
// Revision : 1.0
// ============================================================================
module seg7_stream_decoder
  import seg7_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned HB_BIT         = 12
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic w_clk, w_rst_n, w_sdata, w_sframe, w_confirm;
  logic w_unused_pins;

  assign w_clk         = io_in[0];
  assign w_rst_n       = io_in[1];
  assign w_sdata       = io_in[2];
  assign w_sframe      = io_in[3];
  assign w_confirm     = io_in[4];
  assign w_unused_pins = &{1'b0, io_in[7:5]};

  seg7_state_t r_state, w_state_next;
  logic        w_start, w_shift_in;
  logic [6:0]  r_shift, r_prev;
  logic [3:0]  r_count;
  logic        r_overrun;
  logic [3:0]  r_nibble;
  logic        r_valid, r_err;
  logic [HB_BIT:0] r_hb_cnt;

  logic [6:0] w_pattern;
  logic       w_hit, w_frame_ok, w_accept;
  logic [3:0] w_lut_nibble;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift_in   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sframe) begin
          w_start      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_sframe) w_shift_in   = 1'b1;
        else          w_state_next = CHECK;
      end
      CHECK: begin
        // A frame may start in the same cycle the previous one is evaluated.
        if (w_sframe) begin
          w_start      = 1'b1;
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift   <= 7'd0;
      r_count   <= 4'd0;
      r_overrun <= 1'b0;
    end else if (w_start) begin
      r_shift   <= {6'd0, w_sdata};
      r_count   <= 4'd1;
      r_overrun <= 1'b0;
    end else if (w_shift_in) begin
      if (r_count < 4'd7) r_shift[r_count[2:0]] <= w_sdata;
      else                r_overrun             <= 1'b1;
      if (r_count != 4'd8) r_count <= r_count + 4'd1;
    end
  end

  assign w_pattern = SEG_ACTIVE_LOW ? ~r_shift : r_shift;

  seg7_pattern_lut u_lut (
    .i_pattern (w_pattern),
    .o_hit     (w_hit),
    .o_nibble  (w_lut_nibble)
  );

  assign w_frame_ok = (r_count == 4'd7) && !r_overrun;
  assign w_accept   = w_frame_ok && w_hit && (!w_confirm || (w_pattern == r_prev));

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_nibble <= 4'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_prev   <= 7'h00;
    end else begin
      r_valid <= 1'b0;
      if (r_state == CHECK) begin
        if (!w_frame_ok) begin
          r_err <= 1'b1;
        end else begin
          // Any complete frame becomes the reference for confirm mode.
          r_prev <= w_pattern;
          if (!w_hit) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_nibble <= w_lut_nibble;
            r_valid  <= 1'b1;
            r_err    <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_hb_cnt <= '0;
    else          r_hb_cnt <= r_hb_cnt + {{HB_BIT{1'b0}}, 1'b1};
  end

  assign io_out = {r_hb_cnt[HB_BIT], (r_state != IDLE), r_err, r_valid, r_nibble};

endmodule
`default_nettype wire

// File: tb/tb_seg7_stream_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg7_stream_decoder : randomized frame-level bench, active-high and low
// Revision : 1.0
// ============================================================================
module tb_seg7_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n, sdata, sframe, confirm;
  logic [2:0] junk;
  logic [7:0] io_in;
  logic [7:0] out_hi, out_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign io_in = {junk, confirm, sframe, sdata, rst_n, clk};

  seg7_stream_decoder #(.SEG_ACTIVE_LOW(1'b0), .HB_BIT(12)) dut (
    .io_in  (io_in),
    .io_out (out_hi)
  );

  seg7_stream_decoder #(.SEG_ACTIVE_LOW(1'b1), .HB_BIT(4)) dut_al (
    .io_in  (io_in),
    .io_out (out_lo)
  );

  // Reference: digit patterns gfedcba, index = digit value.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_nibble [2];
  logic       m_err    [2];
  logic [6:0] m_prev   [2];
  logic [6:0] last_p;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dout(input int k);
    return (k == 1) ? out_lo : out_hi;
  endfunction

  function automatic int find_digit(input logic [6:0] p);
    int d;
    d = -1;
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) d = i;
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_nibble[k] = 4'd0;
      m_err[k]    = 1'b0;
      m_prev[k]   = 7'h00;
    end
  endtask

  // Frame-level outcome: n serial bits, first bit is segment a.
  task automatic model_frame(input logic [15:0] bits, input int n, input logic conf,
                             output logic [1:0] ev);
    ev = 2'b00;
    for (int k = 0; k < 2; k++) begin
      logic [6:0] p;
      int d;
      p = (k == 1) ? ~bits[6:0] : bits[6:0];
      d = find_digit(p);
      if (n != 7) begin
        m_err[k] = 1'b1;
      end else if (d < 0) begin
        m_err[k]  = 1'b1;
        m_prev[k] = p;
      end else if (!conf || p == m_prev[k]) begin
        m_nibble[k] = 4'(d);
        m_err[k]    = 1'b0;
        m_prev[k]   = p;
        ev[k]       = 1'b1;
      end else begin
        m_prev[k] = p;
      end
    end
  endtask

  task automatic compare_outs(input string tag, input logic [1:0] ev, input logic eb);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] o;
      o = dout(k);
      check_eq($sformatf("%s%0d/nibble", tag, k), 32'(o[3:0]), 32'(m_nibble[k]));
      check_eq($sformatf("%s%0d/valid", tag, k),  32'(o[4]),   32'(ev[k]));
      check_eq($sformatf("%s%0d/err", tag, k),    32'(o[5]),   32'(m_err[k]));
      check_eq($sformatf("%s%0d/busy", tag, k),   32'(o[6]),   32'(eb));
    end
  endtask

  // Entered and left at a falling edge. started: bit a already captured by a
  // preceding CHECK cycle. chain: start the next frame (bit nxt0) during CHECK.
  task automatic send_frame(input string tag, input logic [15:0] bits, input int n,
                            input logic conf, input bit started, input bit chain,
                            input logic nxt0);
    logic [1:0] ev;
    for (int i = (started ? 1 : 0); i < n; i++) begin
      sframe = 1'b1;
      sdata  = bits[i];
      junk   = 3'($urandom);
      @(negedge clk);
    end
    sframe  = 1'b0;
    sdata   = 1'($urandom);
    confirm = conf;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] o;
      o = dout(k);
      check_eq($sformatf("%s%0d/chk_busy", tag, k),  32'(o[6]), 32'd1);
      check_eq($sformatf("%s%0d/chk_valid", tag, k), 32'(o[4]), 32'd0);
    end
    sframe = chain;
    sdata  = chain ? nxt0 : 1'($urandom);
    @(negedge clk);
    model_frame(bits, n, conf, ev);
    compare_outs(tag, ev, chain);
    confirm = 1'($urandom);
    if (!chain) begin
      @(negedge clk);
      compare_outs({tag, "_idle"}, 2'b00, 1'b0);
    end
  endtask

  task automatic pick_frame(output logic [15:0] bits, output int n);
    int r;
    logic [6:0] p;
    r = int'($urandom_range(0, 9));
    if (r < 5)      p = seg_tab[$urandom_range(0, 15)];
    else if (r < 7) p = ~seg_tab[$urandom_range(0, 15)];
    else if (r < 8) p = 7'($urandom);
    else            p = last_p;
    last_p = p;
    n    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : 7;
    bits = {9'($urandom), p};
  endtask

  initial begin
    logic [15:0] cur, nxt;
    int          cur_n, nxt_n;
    bit          started, chain;
    logic [7:0]  o;

    rst_n   = 1'b0;
    sframe  = 1'b0;
    sdata   = 1'b0;
    confirm = 1'b0;
    junk    = 3'd0;
    last_p  = 7'h3F;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_hi", 32'(out_hi), 32'd0);
    check_eq("reset_lo", 32'(out_lo), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame("f06", 16'h0006, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    o = out_lo;
    check_eq("al_inverted_E", 32'(o[3:0]), 32'hE);
    o = out_hi;
    check_eq("plain_one", 32'(o[3:0]), 32'h1);

    send_frame("f77", 16'h0077, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame("f39", 16'h0039, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    o = out_hi;
    check_eq("chain_C", 32'(o[3:0]), 32'hC);

    send_frame("short5", 16'h003F, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("long9",  16'h01BF, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("long8",  16'h00BF, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame("f3F",    16'h003F, 7, 1'b0, 1'b0, 1'b0, 1'b0);

    send_frame("c4F_a", 16'h004F, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame("c4F_b", 16'h004F, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame("c66",   16'h0066, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    o = out_hi;
    check_eq("confirm_hold3", 32'(o[3:0]), 32'h3);

    send_frame("f00", 16'h0000, 7, 1'b0, 1'b0, 1'b0, 1'b0);

    started = 1'b0;
    pick_frame(cur, cur_n);
    for (int i = 0; i < 250; i++) begin
      chain = (i < 249) && ($urandom_range(0, 2) == 0);
      pick_frame(nxt, nxt_n);
      send_frame("rnd", cur, cur_n, 1'($urandom), started, chain, nxt[0]);
      cur     = nxt;
      cur_n   = nxt_n;
      started = chain;
    end

    send_frame("pre_rst", 16'h007F, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sframe = 1'b1;
      sdata  = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_hi", 32'(out_hi), 32'd0);
    check_eq("async_rst_lo", 32'(out_lo), 32'd0);
    @(negedge clk);
    sframe = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    for (int k = 1; k <= 8300; k++) begin
      @(negedge clk);
      check_eq("hb_hi", 32'(out_hi[7]), 32'((k >> 12) & 1));
      check_eq("hb_lo", 32'(out_lo[7]), 32'((k >> 4) & 1));
    end
    compare_outs("post_rst_idle", 2'b00, 1'b0);
    send_frame("post_rst", 16'h005B, 7, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
